// File: rtl/ber_monitor_4_ask_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ber_monitor_4_ask_pkg : shared defaults and FSM encoding for the BER monitor
// Revision 1.0
// ---------------------------------------------------------------------------
package ber_monitor_4_ask_pkg;

  localparam int LFSR_LEN          = 12;
  localparam int DEF_LOCK_THRESH   = 16;
  localparam int DEF_UNLOCK_THRESH = 1024;
  localparam int DEF_WIN_CNT_W     = 8;

  typedef enum logic [0:0] {
    ST_WAIT_SYNC = 1'b0,
    ST_MEASURE   = 1'b1
  } ber_state_e;

endpackage
`default_nettype wire

// File: rtl/ber_monitor_4_ask_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : accumulator that sticks at all-ones; q_next exposes the value
// the counter would take this step so the owner can latch it. Revision 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W     = 8,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     q,
  output logic [W-1:0]     q_next
);

  logic [W:0] sum;

  always_comb begin
    sum    = {1'b0, q} + {{(W + 1 - INC_W){1'b0}}, inc};
    q_next = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : q_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ber_monitor_4_ask.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ber_monitor_4_ask : per-window symbol/bit error counting with lock hysteresis
// Revision 1.0
// ---------------------------------------------------------------------------
module ber_monitor_4_ask
  import ber_monitor_4_ask_pkg::*;
#(
  parameter int CNT_W         = LFSR_LEN,
  parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
  parameter int UNLOCK_THRESH = DEF_UNLOCK_THRESH,
  parameter int WIN_CNT_W     = DEF_WIN_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sym_clk_en,
  input  logic                 hold,
  input  logic [1:0]           rx_data,
  input  logic [1:0]           tx_data_ref,
  output logic [CNT_W-1:0]     sym_err_cnt,
  output logic [CNT_W:0]       bit_err_cnt,
  output logic [CNT_W-1:0]     sym_cnt,
  output logic                 win_valid,
  output logic [WIN_CNT_W-1:0] win_cnt,
  output logic                 locked,
  output logic                 measuring
);

  ber_state_e       state, state_next;
  logic             acc_en;
  logic             close_win;
  logic [1:0]       diff;
  logic [1:0]       bit_inc;
  logic             sym_inc;
  logic [CNT_W-1:0] sym_q, sym_nx;
  logic [CNT_W-1:0] serr_q, serr_nx;
  logic [CNT_W:0]   berr_q, berr_nx;

  always_comb begin
    diff    = rx_data ^ tx_data_ref;
    bit_inc = {1'b0, diff[1]} + {1'b0, diff[0]};
    sym_inc = |diff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_WAIT_SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    acc_en     = 1'b0;
    close_win  = 1'b0;
    measuring  = (state == ST_MEASURE);
    case (state)
      ST_WAIT_SYNC: if (sym_clk_en && hold) state_next = ST_MEASURE;
      ST_MEASURE: begin
        acc_en    = sym_clk_en;
        close_win = sym_clk_en && hold;
      end
      default: state_next = ST_WAIT_SYNC;
    endcase
  end

  sat_counter #(.W(CNT_W), .INC_W(1)) u_sym_acc (
    .clk(clk), .reset_n(reset_n), .en(acc_en), .clr(close_win),
    .inc(1'b1), .q(sym_q), .q_next(sym_nx)
  );

  sat_counter #(.W(CNT_W), .INC_W(1)) u_serr_acc (
    .clk(clk), .reset_n(reset_n), .en(acc_en), .clr(close_win),
    .inc(sym_inc), .q(serr_q), .q_next(serr_nx)
  );

  sat_counter #(.W(CNT_W + 1), .INC_W(2)) u_berr_acc (
    .clk(clk), .reset_n(reset_n), .en(acc_en), .clr(close_win),
    .inc(bit_inc), .q(berr_q), .q_next(berr_nx)
  );

  // Latched results capture the accumulators including the closing symbol.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_err_cnt <= '0;
      bit_err_cnt <= '0;
      sym_cnt     <= '0;
      win_valid   <= 1'b0;
      win_cnt     <= '0;
      locked      <= 1'b0;
    end else begin
      win_valid <= close_win;
      if (close_win) begin
        sym_err_cnt <= serr_nx;
        bit_err_cnt <= berr_nx;
        sym_cnt     <= sym_nx;
        win_cnt     <= win_cnt + WIN_CNT_W'(1);
        if (32'(serr_nx) < LOCK_THRESH)        locked <= 1'b1;
        else if (32'(serr_nx) > UNLOCK_THRESH) locked <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
